// File: rtl/branch_control_unit.sv
// Decode-stage branch/jump resolver with circular return-address stack.
// Optional BCU_STATS_EN adds saturating taken/stall/flush counters.
module branch_control_unit #(
    parameter int RAS_DEPTH = 8,
    parameter int PTR_W     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [15:0] NPC,
    input  logic [15:0] instruction,
    input  logic [15:0] rs_val,
    input  logic [15:0] rt_val,
    input  logic        operands_ready,
    output logic [1:0]  PCsrc,
    output logic [15:0] I_TypeImmediate,
    output logic [15:0] J_TypeImmediate,
    output logic [15:0] ReturnAddress,
    output logic        stall,
    output logic        flush,
    output logic        ras_err
`ifdef BCU_STATS_EN
    ,
    output logic [15:0] taken_cnt,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    localparam logic [3:0] OP_BEQ  = 4'h8;
    localparam logic [3:0] OP_BNE  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_CALL = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(RAS_DEPTH);

    typedef enum logic [1:0] {
        RUN,
        HOLD,
        FLUSH
    } state_t;

    state_t state;
    state_t state_nx;

    logic [15:0]      ras [RAS_DEPTH];
    logic [PTR_W-1:0] tp;
    logic [PTR_W:0]   cnt;

    logic [3:0]  opcode;
    logic [15:0] pc_id;
    logic        push;
    logic        pop;
    logic        taken;

    assign opcode = instruction[15:12];
    assign pc_id  = NPC - 16'd1;

    assign I_TypeImmediate = pc_id + {{10{instruction[5]}}, instruction[5:0]};
    assign J_TypeImmediate = {pc_id[15:12], instruction[11:0]};
    assign ReturnAddress   = (cnt != '0) ? ras[tp] : 16'h0000;

    // Resolve the decode instruction: redirect, stall and next state.
    always_comb begin
        PCsrc    = 2'b00;
        stall    = 1'b0;
        flush    = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        taken    = 1'b0;
        state_nx = RUN;
        if (!reset && id_valid && state != FLUSH) begin
            case (opcode)
                OP_BEQ, OP_BNE: begin
                    if (!operands_ready) begin
                        stall    = 1'b1;
                        state_nx = HOLD;
                    end else begin
                        taken = (opcode == OP_BEQ) ==
                                (rs_val == rt_val);
                        if (taken) begin
                            PCsrc    = 2'b10;
                            flush    = 1'b1;
                            state_nx = FLUSH;
                        end
                    end
                end
                OP_JMP: begin
                    PCsrc    = 2'b01;
                    flush    = 1'b1;
                    state_nx = FLUSH;
                end
                OP_CALL: begin
                    PCsrc    = 2'b01;
                    flush    = 1'b1;
                    push     = 1'b1;
                    state_nx = FLUSH;
                end
                OP_RET: begin
                    PCsrc    = 2'b11;
                    flush    = 1'b1;
                    pop      = 1'b1;
                    state_nx = FLUSH;
                end
                default: state_nx = RUN;
            endcase
        end
    end

    // Control state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // Return-address stack: push overwrites oldest when full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tp      <= '0;
            cnt     <= '0;
            ras_err <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else if (push) begin
            ras[tp + PTR_W'(1)] <= NPC;
            tp <= tp + PTR_W'(1);
            if (cnt == FULL) begin
                ras_err <= 1'b1;
            end else begin
                cnt <= cnt + (PTR_W+1)'(1);
            end
        end else if (pop) begin
            if (cnt != '0) begin
                tp  <= tp - PTR_W'(1);
                cnt <= cnt - (PTR_W+1)'(1);
            end else begin
                ras_err <= 1'b1;
            end
        end
    end

`ifdef BCU_STATS_EN
    // Saturating event counters for redirects, stalls and flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (PCsrc != 2'b00 && taken_cnt != 16'hFFFF) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
            if (stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (flush && flush_cnt != 16'hFFFF) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_control_unit.sv
// Self-checking bench for branch_control_unit: directed plan
// plus random decode traffic against a queue-based reference model.
module tb_branch_control_unit;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [15:0] NPC = '0;
    logic [15:0] instruction = '0;
    logic [15:0] rs_val = '0;
    logic [15:0] rt_val = '0;
    logic        operands_ready = 1'b0;
    logic [1:0]  PCsrc;
    logic [15:0] I_TypeImmediate;
    logic [15:0] J_TypeImmediate;
    logic [15:0] ReturnAddress;
    logic        stall;
    logic        flush;
    logic        ras_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [15:0] mq[$];
    bit          m_flush_slot;
    bit          m_err;

    branch_control_unit #(.RAS_DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk(clk),
        .reset(reset),
        .id_valid(id_valid),
        .NPC(NPC),
        .instruction(instruction),
        .rs_val(rs_val),
        .rt_val(rt_val),
        .operands_ready(operands_ready),
        .PCsrc(PCsrc),
        .I_TypeImmediate(I_TypeImmediate),
        .J_TypeImmediate(J_TypeImmediate),
        .ReturnAddress(ReturnAddress),
        .stall(stall),
        .flush(flush),
        .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one decode cycle, check outputs, then advance the model.
    task automatic step(input logic v, input logic [15:0] npc,
                        input logic [15:0] ins, input logic [15:0] rs,
                        input logic [15:0] rt, input logic rdy);
        int          pc;
        int          off;
        logic [15:0] pcm;
        logic [15:0] e_i;
        logic [15:0] e_j;
        logic [15:0] e_ra;
        logic [1:0]  e_pc;
        logic        e_st;
        logic        e_fl;
        logic [3:0]  op;
        bit          do_push;
        bit          do_pop;
        @(negedge clk);
        id_valid       = v;
        NPC            = npc;
        instruction    = ins;
        rs_val         = rs;
        rt_val         = rt;
        operands_ready = rdy;
        #2;
        op  = ins[15:12];
        pc  = int'(npc) - 1;
        off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
        e_i = 16'(pc + off);
        pcm = npc - 16'd1;
        e_j = {pcm[15:12], ins[11:0]};
        e_ra = (mq.size() > 0) ? mq[mq.size()-1] : 16'h0000;
        e_pc = 2'b00;
        e_st = 1'b0;
        e_fl = 1'b0;
        do_push = 0;
        do_pop  = 0;
        if (m_flush_slot) begin
            m_flush_slot = 0;
        end else if (v) begin
            if (op == 4'h8 || op == 4'h9) begin
                if (!rdy) begin
                    e_st = 1'b1;
                end else if ((op == 4'h8) == (rs == rt)) begin
                    e_pc = 2'b10;
                    e_fl = 1'b1;
                    m_flush_slot = 1;
                end
            end else if (op == 4'hC || op == 4'hD) begin
                e_pc = 2'b01;
                e_fl = 1'b1;
                m_flush_slot = 1;
                do_push = (op == 4'hD);
            end else if (op == 4'hE) begin
                e_pc = 2'b11;
                e_fl = 1'b1;
                m_flush_slot = 1;
                do_pop = 1;
            end
        end
        chk("PCsrc", 16'(PCsrc), 16'(e_pc));
        chk("stall", 16'(stall), 16'(e_st));
        chk("flush", 16'(flush), 16'(e_fl));
        chk("ras_err", 16'(ras_err), 16'(m_err));
        chk("I_imm", I_TypeImmediate, e_i);
        chk("J_imm", J_TypeImmediate, e_j);
        chk("RetAddr", ReturnAddress, e_ra);
        if (do_push) begin
            mq.push_back(npc);
            if (mq.size() > DEPTH) begin
                void'(mq.pop_front());
                m_err = 1;
            end
        end
        if (do_pop) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else m_err = 1;
        end
    endtask

    // Assert reset asynchronously mid-cycle and check settled outputs.
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_PCsrc", 16'(PCsrc), 16'h0000);
        chk("rst_stall", 16'(stall), 16'h0000);
        chk("rst_flush", 16'(flush), 16'h0000);
        chk("rst_ras_err", 16'(ras_err), 16'h0000);
        chk("rst_RetAddr", ReturnAddress, 16'h0000);
        mq.delete();
        m_flush_slot = 0;
        m_err = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [15:0] r_ins;
        logic [3:0]  r_op;
        m_flush_slot = 0;
        m_err = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset while a BEQ is holding for operands
        step(1, 16'h0050, 16'h8000, 16'd1, 16'd2, 0);
        step(1, 16'h0050, 16'h8000, 16'd1, 16'd2, 0);
        do_reset();

        // Taken BEQ with negative offset, then the flush slot
        step(1, 16'h0011, 16'h803E, 16'h1234, 16'h1234, 1);
        step(1, 16'h0012, 16'h8001, 16'h1234, 16'h1234, 1);
        step(0, 16'h000F, 16'h0000, 16'h0, 16'h0, 1);

        // BNE stalls three cycles then falls through
        for (int i = 0; i < 3; i++)
            step(1, 16'h0100, 16'h9005, 16'd5, 16'd5, 0);
        step(1, 16'h0100, 16'h9005, 16'd5, 16'd5, 1);

        // CALL then RET through the stack
        step(1, 16'h4001, 16'hD123, 16'h0, 16'h0, 1);
        step(1, 16'h4124, 16'h0000, 16'h0, 16'h0, 1);
        step(1, 16'h4125, 16'hE000, 16'h0, 16'h0, 1);
        step(1, 16'h4126, 16'h0000, 16'h0, 16'h0, 1);

        // Nine CALLs overflow the eight-entry stack, nine RETs drain it
        for (int i = 1; i <= 9; i++) begin
            step(1, 16'(i), 16'hD000, 16'h0, 16'h0, 1);
            step(1, 16'h0000, 16'h0000, 16'h0, 16'h0, 1);
        end
        for (int i = 0; i < 9; i++) begin
            step(1, 16'h2000, 16'hE000, 16'h0, 16'h0, 1);
            step(1, 16'h0000, 16'h0000, 16'h0, 16'h0, 1);
        end

        // RET in the CALL's flush slot is ignored
        do_reset();
        step(1, 16'h0777, 16'hD010, 16'h0, 16'h0, 1);
        step(1, 16'h0778, 16'hE000, 16'h0, 16'h0, 1);
        step(1, 16'h0900, 16'hE000, 16'h0, 16'h0, 1);
        step(1, 16'h0901, 16'h0000, 16'h0, 16'h0, 1);
        step(1, 16'h0902, 16'hE000, 16'h0, 16'h0, 1);
        step(1, 16'h0903, 16'h0000, 16'h0, 16'h0, 1);

        // Random decode traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            r_op  = 4'($urandom_range(0, 15));
            r_ins = {r_op, 12'($urandom)};
            step($urandom_range(0, 7) != 0, 16'($urandom), r_ins,
                 16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
